// File: rtl/wb_lsu_pkg.sv
// Shared encodings for the Wishbone load/store unit: access sizes, response causes
// and controller state values.
package wb_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] CAUSE_OK       = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBus     = 2'd1;
  localparam logic [1:0] StBackoff = 2'd2;
  localparam logic [1:0] StResp    = 2'd3;

endpackage

// File: rtl/wb_lsu_lane.sv
// Byte-lane steering: places store data and byte selects at the address offset, and
// extracts and sign/zero-extends a load result from the bus word.
module wb_lsu_lane
  import wb_lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned SEL_W = DATA_WIDTH / 8,
  localparam int unsigned OFF_W = $clog2(SEL_W)
) (
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] st_data_o,
  output logic [SEL_W-1:0]      st_sel_o,
  output logic [DATA_WIDTH-1:0] ld_data_o
);

  int unsigned           nbytes;
  logic [SEL_W-1:0]      byte_en;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic                  sign;

  always_comb begin
    nbytes = 32'd1 << size_i;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      byte_en[i] = (i < nbytes);
    end
    st_sel_o  = byte_en << offset_i;
    st_data_o = wdata_i << {offset_i, 3'b000};

    shifted = rdata_i >> {offset_i, 3'b000};
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      keep[i] = (i < 8 * nbytes);
    end
    unique case (size_i)
      SIZE_B:  sign = shifted[7];
      SIZE_H:  sign = shifted[15];
      SIZE_W:  sign = shifted[31];
      default: sign = shifted[DATA_WIDTH-1];
    endcase
    // Bits above the accessed field are filled with the sign for signed loads.
    ld_data_o = (shifted & keep) | ({DATA_WIDTH{sign & ~unsigned_i}} & ~keep);
  end

endmodule

// File: rtl/wb_lsu.sv
// Wishbone load/store master with misalignment trapping, bounded rty_i retries,
// err_i reporting and a per-attempt termination timeout.
module wb_lsu
  import wb_lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SEL_W = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_cause_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  rty_i,
  output logic                  stb_o,
  output logic                  cyc_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [SEL_W-1:0]      sel_o
);

  localparam int unsigned OFF_W = $clog2(SEL_W);
  localparam int unsigned RW    = $clog2(MAX_RETRY + 2);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 2);

  logic [1:0]            state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            cause_q, cause_d;

  logic                  misalign;
  logic                  fin;
  logic [1:0]            fin_cause;
  logic [DATA_WIDTH-1:0] fin_rdata;
  logic [1:0]            lane_size;
  logic [OFF_W-1:0]      lane_off;
  logic [DATA_WIDTH-1:0] lane_st_data;
  logic [SEL_W-1:0]      lane_st_sel;
  logic [DATA_WIDTH-1:0] lane_ld_data;

  // The lane steers the incoming request while idle and the latched one afterwards.
  assign lane_size = (state_q == StIdle) ? req_size_i : size_q;
  assign lane_off  = (state_q == StIdle) ? req_addr_i[OFF_W-1:0] : off_q;

  wb_lsu_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .size_i     (lane_size),
    .unsigned_i (uns_q),
    .offset_i   (lane_off),
    .wdata_i    (req_wdata_i),
    .rdata_i    (dat_i),
    .st_data_o  (lane_st_data),
    .st_sel_o   (lane_st_sel),
    .ld_data_o  (lane_ld_data)
  );

  always_comb begin
    unique case (req_size_i)
      SIZE_B:  misalign = 1'b0;
      SIZE_H:  misalign = req_addr_i[0];
      SIZE_W:  misalign = |req_addr_i[1:0];
      default: misalign = (DATA_WIDTH == 32) || (|req_addr_i[2:0]);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    cause_d     = cause_q;
    fin         = 1'b0;
    fin_cause   = CAUSE_OK;
    fin_rdata   = '0;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          off_d   = req_addr_i[OFF_W-1:0];
          retry_d = '0;
          timer_d = '0;
          if (misalign) begin
            fin       = 1'b1;
            fin_cause = CAUSE_MISALIGN;
          end else begin
            state_d = StBus;
            cyc_d   = 1'b1;
            we_d    = req_we_i;
            adr_d   = req_addr_i & ~ADDR_WIDTH'(SEL_W - 1);
            sel_d   = req_we_i ? lane_st_sel : '1;
            dat_d   = req_we_i ? lane_st_data : '0;
          end
        end
      end
      StBus: begin
        if (ack_i) begin
          fin       = 1'b1;
          fin_rdata = we_q ? '0 : lane_ld_data;
        end else if (err_i) begin
          fin       = 1'b1;
          fin_cause = CAUSE_BUSERR;
        end else if (rty_i) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            state_d = StBackoff;
            cyc_d   = 1'b0;
            retry_d = retry_q + 1'b1;
          end else begin
            fin       = 1'b1;
            fin_cause = CAUSE_BUSERR;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            fin       = 1'b1;
            fin_cause = CAUSE_TIMEOUT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      StBackoff: begin
        state_d = StBus;
        cyc_d   = 1'b1;
        timer_d = '0;
      end
      default: state_d = StIdle;
    endcase

    if (fin) begin
      state_d     = StResp;
      cyc_d       = 1'b0;
      we_d        = 1'b0;
      rsp_valid_d = 1'b1;
      cause_d     = fin_cause;
      rdata_d     = fin_rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      off_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      cause_q     <= CAUSE_OK;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      cause_q     <= cause_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign sel_o       = sel_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_cause_o = cause_q;

endmodule

// File: tb/tb_wb_lsu.sv
// Self-checking bench for wb_lsu: directed scenarios plus randomized accesses against a
// transaction-level reference model, on a 32-bit instance and a 64-bit instance.
module tb_wb_lsu;

  localparam int T_ACK = 0, T_ERR = 1, T_RTY = 2, T_SIL = 3, T_ACKERR = 4, T_ERRRTY = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_cause;
  logic [31:0] s_dat = 0, m_dat, adr;
  logic        ack = 0, err = 0, rty = 0;
  logic        stb, cyc, we;
  logic [3:0]  sel;

  // 64-bit instance
  logic        w_req_valid = 0, w_req_we = 0, w_req_unsigned = 0;
  logic [1:0]  w_req_size = 0;
  logic [31:0] w_req_addr = 0;
  logic [63:0] w_req_wdata = 0;
  logic        w_req_ready, w_rsp_valid;
  logic [63:0] w_rsp_rdata;
  logic [1:0]  w_rsp_cause;
  logic [63:0] w_s_dat = 0, w_m_dat;
  logic        w_ack = 0;
  logic        w_stb, w_cyc, w_we;
  logic [31:0] w_adr;
  logic [7:0]  w_sel;

  wb_lsu #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .MAX_RETRY (3), .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n),
    .req_valid_i (req_valid), .req_ready_o (req_ready), .req_we_i (req_we),
    .req_size_i (req_size), .req_unsigned_i (req_unsigned), .req_addr_i (req_addr),
    .req_wdata_i (req_wdata), .rsp_valid_o (rsp_valid), .rsp_rdata_o (rsp_rdata),
    .rsp_cause_o (rsp_cause), .dat_i (s_dat), .dat_o (m_dat),
    .ack_i (ack), .err_i (err), .rty_i (rty),
    .stb_o (stb), .cyc_o (cyc), .we_o (we), .adr_o (adr), .sel_o (sel)
  );

  wb_lsu #(
    .DATA_WIDTH (64), .ADDR_WIDTH (32), .MAX_RETRY (3), .TIMEOUT_CYCLES (255)
  ) dut64 (
    .clk_i (clk), .rst_ni (rst_n),
    .req_valid_i (w_req_valid), .req_ready_o (w_req_ready), .req_we_i (w_req_we),
    .req_size_i (w_req_size), .req_unsigned_i (w_req_unsigned), .req_addr_i (w_req_addr),
    .req_wdata_i (w_req_wdata), .rsp_valid_o (w_rsp_valid), .rsp_rdata_o (w_rsp_rdata),
    .rsp_cause_o (w_rsp_cause), .dat_i (w_s_dat), .dat_o (w_m_dat),
    .ack_i (w_ack), .err_i (1'b0), .rty_i (1'b0),
    .stb_o (w_stb), .cyc_o (w_cyc), .we_o (w_we), .adr_o (w_adr), .sel_o (w_sel)
  );

  int compared = 0;
  int mismatched = 0;

  // Slave plan: per attempt, wait states before the termination and its kind.
  int plan_w[8];
  int plan_t[8];

  // Observations from the last access
  logic [1:0]  o_cause;
  logic [31:0] o_rdata, o_adr, o_dat;
  logic [3:0]  o_sel;
  logic        o_we;
  int          o_lat, o_att, o_gaps, o_cyc_cycles;
  bit          o_same, o_stb_ok, o_ready_after, o_extra_rsp;

  // Model expectations
  logic [1:0]  e_cause;
  logic [31:0] e_rdata, e_adr, e_dat;
  logic [3:0]  e_sel;
  int          e_lat, e_att;

  task automatic plan_all(input int t, input int w);
    for (int i = 0; i < 8; i++) begin
      plan_t[i] = t;
      plan_w[i] = w;
    end
  endtask

  function automatic void model(input logic we_in, input logic [1:0] size_in,
                                input logic uns_in, input logic [31:0] addr_in,
                                input logic [31:0] wdata_in, input logic [31:0] rdat_in);
    int bytes, off, s;
    bit mis;
    logic [63:0] tmp, span, lane;
    bytes = 1 << size_in;
    off   = int'(addr_in % 4);
    mis   = (addr_in % bytes != 0) || (size_in == 2'd3);
    e_rdata = 0; e_adr = 0; e_sel = 0; e_dat = 0;
    if (mis) begin
      e_cause = 2'd1; e_lat = 1; e_att = 0;
      return;
    end
    e_adr = addr_in - off;
    s     = ((1 << bytes) - 1) << off;
    e_sel = we_in ? s[3:0] : 4'hF;
    tmp   = {32'b0, wdata_in} << (8 * off);
    e_dat = we_in ? tmp[31:0] : 32'h0;
    e_lat = 1;
    e_att = 0;
    e_cause = 2'd0;
    for (int k = 0; k < 8; k++) begin
      e_att++;
      if (plan_t[k] == T_SIL) begin
        e_lat += 8; e_cause = 2'd3; break;
      end
      e_lat += plan_w[k] + 1;
      if (plan_t[k] == T_ACK || plan_t[k] == T_ACKERR) begin
        e_cause = 2'd0; break;
      end
      if (plan_t[k] == T_ERR || plan_t[k] == T_ERRRTY) begin
        e_cause = 2'd2; break;
      end
      if (k < 3) e_lat += 1;
      else begin
        e_cause = 2'd2; break;
      end
    end
    if (!we_in && e_cause == 2'd0) begin
      span = 64'd1 << (8 * bytes);
      lane = ({32'b0, rdat_in} >> (8 * off)) % span;
      if (!uns_in && lane >= span / 2) lane = lane - span;
      e_rdata = lane[31:0];
    end
  endfunction

  // Issues one request at the current negedge and plays the slave; ends on a negedge
  // one cycle after the response, where a new request may be issued.
  task automatic run_access(input logic we_in, input logic [1:0] size_in, input logic uns_in,
                            input logic [31:0] addr_in, input logic [31:0] wdata_in,
                            input logic [31:0] rdat_in, input bit junk);
    int  w;
    bit  in_att, done;
    req_valid = 1; req_we = we_in; req_size = size_in; req_unsigned = uns_in;
    req_addr = addr_in; req_wdata = wdata_in; s_dat = rdat_in;
    o_att = 0; o_gaps = 0; o_lat = -1; o_cyc_cycles = 0; o_same = 1; o_stb_ok = 1;
    o_cause = 'x; o_rdata = 'x; o_adr = 'x; o_sel = 'x; o_dat = 'x; o_we = 'x;
    in_att = 0; done = 0; w = 0;
    for (int t = 1; t <= 200 && !done; t++) begin
      @(negedge clk);
      req_valid = 0;
      if (stb !== cyc) o_stb_ok = 0;
      ack = 0; err = 0; rty = 0;
      if (rsp_valid) begin
        o_lat = t; o_cause = rsp_cause; o_rdata = rsp_rdata; done = 1;
      end else if (cyc) begin
        o_cyc_cycles++;
        if (!in_att) begin
          in_att = 1; o_att++; w = 0;
          if (o_att == 1) begin
            o_adr = adr; o_sel = sel; o_dat = m_dat; o_we = we;
          end else if (adr !== o_adr || sel !== o_sel || m_dat !== o_dat || we !== o_we) begin
            o_same = 0;
          end
        end
        if (o_att <= 8 && w == plan_w[o_att-1]) begin
          case (plan_t[o_att-1])
            T_ACK:    ack = 1;
            T_ERR:    err = 1;
            T_RTY:    rty = 1;
            T_ACKERR: begin ack = 1; err = 1; end
            T_ERRRTY: begin err = 1; rty = 1; end
            default:  ;
          endcase
        end
        w++;
      end else begin
        if (o_att > 0) o_gaps++;
        in_att = 0;
        if (junk) begin
          ack = 1'($urandom_range(0, 1));
          err = 1'($urandom_range(0, 1));
          rty = 1'($urandom_range(0, 1));
        end
      end
    end
    @(negedge clk);
    ack = 0; err = 0; rty = 0;
    o_ready_after = req_ready;
    o_extra_rsp   = rsp_valid;
  endtask

  task automatic test_reset;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    compared++;
    if ({req_ready, cyc, stb, we, rsp_valid, rsp_cause, adr, sel, m_dat, rsp_rdata} !==
        {1'b1, 4'b0, 2'b0, 32'b0, 4'b0, 32'b0, 32'b0}) begin
      mismatched++;
      $display("FAIL reset_state: ready=%b cyc=%b stb=%b we=%b rv=%b cause=%0d adr=%h sel=%h dat=%h rd=%h want ready=1 rest 0",
               req_ready, cyc, stb, we, rsp_valid, rsp_cause, adr, sel, m_dat, rsp_rdata);
    end
    rst_n = 1;
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1 || w_req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b/%b want 1/1", req_ready, w_req_ready);
    end
  endtask

  task automatic test_load_byte;
    plan_all(T_ACK, 0);
    run_access(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80AB_CDEF, 1'b0);
    compared++;
    if (o_adr !== 32'h1000 || o_sel !== 4'hF || o_we !== 1'b0) begin
      mismatched++;
      $display("FAIL load_byte_bus: adr=%h sel=%h we=%b want 1000 f 0", o_adr, o_sel, o_we);
    end
    compared++;
    if (o_rdata !== 32'hFFFF_FF80 || o_cause !== 2'd0) begin
      mismatched++;
      $display("FAIL load_byte_rsp: rdata=%h cause=%0d want ffffff80 0", o_rdata, o_cause);
    end
    compared++;
    if (o_lat !== 2 || o_ready_after !== 1'b1 || o_extra_rsp !== 1'b0) begin
      mismatched++;
      $display("FAIL load_byte_latency: lat=%0d ready_n3=%b extra=%b want 2 1 0",
               o_lat, o_ready_after, o_extra_rsp);
    end
  endtask

  task automatic test_store_half;
    plan_all(T_ACK, 3);
    run_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h1234_5678, 1'b0);
    compared++;
    if (o_dat !== 32'hBEEF_0000 || o_sel !== 4'hC || o_we !== 1'b1 || o_adr !== 32'h2000) begin
      mismatched++;
      $display("FAIL store_half_bus: dat=%h sel=%h we=%b adr=%h want beef0000 c 1 2000",
               o_dat, o_sel, o_we, o_adr);
    end
    compared++;
    if (o_cause !== 2'd0 || o_lat !== 5 || o_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL store_half_rsp: cause=%0d lat=%0d rdata=%h want 0 5 0", o_cause, o_lat, o_rdata);
    end
  endtask

  task automatic test_misalign;
    plan_all(T_ACK, 0);
    run_access(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'hFFFF_FFFF, 1'b0);
    compared++;
    if (o_att !== 0 || o_lat !== 1 || o_cause !== 2'd1 || o_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL misalign_word: att=%0d lat=%0d cause=%0d rdata=%h want 0 1 1 0",
               o_att, o_lat, o_cause, o_rdata);
    end
    run_access(1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 32'hFFFF_FFFF, 1'b0);
    compared++;
    if (o_att !== 0 || o_cause !== 2'd1) begin
      mismatched++;
      $display("FAIL misalign_double32: att=%0d cause=%0d want 0 1", o_att, o_cause);
    end
  endtask

  task automatic test_retry;
    plan_all(T_RTY, 1);
    plan_t[3] = T_ACK;
    run_access(1'b1, 2'd2, 1'b0, 32'h4000, 32'hCAFE_F00D, 32'h0, 1'b1);
    compared++;
    if (o_att !== 4 || o_gaps !== 3 || o_same !== 1'b1 || o_cause !== 2'd0) begin
      mismatched++;
      $display("FAIL retry_then_ack: att=%0d gaps=%0d same=%b cause=%0d want 4 3 1 0",
               o_att, o_gaps, o_same, o_cause);
    end
    plan_all(T_RTY, 0);
    run_access(1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 32'h0, 1'b0);
    compared++;
    if (o_att !== 4 || o_cause !== 2'd2 || o_lat !== 8) begin
      mismatched++;
      $display("FAIL retry_exhausted: att=%0d cause=%0d lat=%0d want 4 2 8", o_att, o_cause, o_lat);
    end
  endtask

  task automatic test_timeout_priority;
    plan_all(T_SIL, 0);
    run_access(1'b0, 2'd2, 1'b1, 32'h5000, 32'h0, 32'h0, 1'b0);
    compared++;
    if (o_cyc_cycles !== 8 || o_cause !== 2'd3 || o_lat !== 9) begin
      mismatched++;
      $display("FAIL timeout: cyc_cycles=%0d cause=%0d lat=%0d want 8 3 9",
               o_cyc_cycles, o_cause, o_lat);
    end
    plan_all(T_ERRRTY, 0);
    run_access(1'b0, 2'd0, 1'b0, 32'h5001, 32'h0, 32'h0, 1'b0);
    compared++;
    if (o_att !== 1 || o_cause !== 2'd2) begin
      mismatched++;
      $display("FAIL err_over_rty: att=%0d cause=%0d want 1 2", o_att, o_cause);
    end
    plan_all(T_ACKERR, 2);
    run_access(1'b0, 2'd1, 1'b1, 32'h5002, 32'h0, 32'h9876_0000, 1'b0);
    compared++;
    if (o_cause !== 2'd0 || o_rdata !== 32'h0000_9876) begin
      mismatched++;
      $display("FAIL ack_over_err: cause=%0d rdata=%h want 0 00009876", o_cause, o_rdata);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_rsp;
    saw_rsp = 0;
    plan_all(T_SIL, 0);
    req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h6000;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    compared++;
    if (cyc !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_busy: cyc=%b want 1", cyc);
    end
    #2 rst_n = 0;
    #1;
    compared++;
    if (cyc !== 1'b0 || stb !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_async: cyc=%b stb=%b want 0 0", cyc, stb);
    end
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
    end
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
    end
    compared++;
    if (saw_rsp !== 1'b0 || req_ready !== 1'b1 || cyc !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_after: rsp_seen=%b ready=%b cyc=%b want 0 1 0",
               saw_rsp, req_ready, cyc);
    end
  endtask

  task automatic dw64_load(input string name, input logic [1:0] size_in, input logic uns_in,
                           input logic [31:0] addr_in, input logic [63:0] data,
                           input logic [7:0] exp_sel, input logic [31:0] exp_adr,
                           input logic [63:0] exp_rdata);
    logic [7:0]  got_sel;
    logic [31:0] got_adr;
    logic [63:0] got_rdata;
    logic [1:0]  got_cause;
    int          lat;
    got_sel = 'x; got_adr = 'x; got_rdata = 'x; got_cause = 'x; lat = -1;
    w_req_valid = 1; w_req_we = 0; w_req_size = size_in; w_req_unsigned = uns_in;
    w_req_addr = addr_in; w_s_dat = data;
    for (int t = 1; t <= 50 && lat < 0; t++) begin
      @(negedge clk);
      w_req_valid = 0;
      w_ack = w_cyc;
      if (w_cyc && t == 1) begin
        got_sel = w_sel; got_adr = w_adr;
      end
      if (w_rsp_valid) begin
        lat = t; got_rdata = w_rsp_rdata; got_cause = w_rsp_cause;
      end
    end
    w_ack = 0;
    @(negedge clk);
    compared++;
    if (got_sel !== exp_sel || got_adr !== exp_adr || lat !== 2) begin
      mismatched++;
      $display("FAIL %s_bus: sel=%h adr=%h lat=%0d want %h %h 2",
               name, got_sel, got_adr, lat, exp_sel, exp_adr);
    end
    compared++;
    if (got_rdata !== exp_rdata || got_cause !== 2'd0) begin
      mismatched++;
      $display("FAIL %s_rsp: rdata=%h cause=%0d want %h 0", name, got_rdata, got_cause, exp_rdata);
    end
  endtask

  task automatic test_dw64;
    dw64_load("dw64_double", 2'd3, 1'b0, 32'h8, 64'h8123_4567_89AB_CDEF, 8'hFF, 32'h8,
              64'h8123_4567_89AB_CDEF);
    dw64_load("dw64_half", 2'd1, 1'b0, 32'h1E, 64'h8001_2345_6789_ABCD, 8'hFF, 32'h18,
              64'hFFFF_FFFF_FFFF_8001);
  endtask

  task automatic test_random;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd;
    logic        w_r, u_r;
    int          r;
    for (int n = 0; n < 60; n++) begin
      sz  = 2'($urandom_range(0, 3));
      w_r = 1'($urandom_range(0, 1));
      u_r = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      wd  = $urandom;
      rd  = $urandom;
      for (int k = 0; k < 8; k++) begin
        r = int'($urandom_range(0, 11));
        plan_w[k] = int'($urandom_range(0, 3));
        plan_t[k] = (r < 5) ? T_ACK : (r == 5) ? T_ERR : (r < 9) ? T_RTY :
                    (r == 9) ? T_ACKERR : (r == 10) ? T_ERRRTY : T_SIL;
      end
      model(w_r, sz, u_r, a, wd, rd);
      run_access(w_r, sz, u_r, a, wd, rd, 1'b1);
      compared++;
      if (o_cause !== e_cause || o_rdata !== e_rdata || o_lat !== e_lat || o_att !== e_att) begin
        mismatched++;
        $display("FAIL random_rsp[%0d]: cause=%0d rdata=%h lat=%0d att=%0d want %0d %h %0d %0d",
                 n, o_cause, o_rdata, o_lat, o_att, e_cause, e_rdata, e_lat, e_att);
      end
      if (e_att > 0) begin
        compared++;
        if (o_adr !== e_adr || o_sel !== e_sel || o_we !== w_r || (w_r && o_dat !== e_dat) ||
            o_same !== 1'b1 || o_gaps !== e_att - 1 || o_stb_ok !== 1'b1) begin
          mismatched++;
          $display("FAIL random_bus[%0d]: adr=%h sel=%h we=%b dat=%h same=%b gaps=%0d stb_ok=%b want %h %h %b %h 1 %0d 1",
                   n, o_adr, o_sel, o_we, o_dat, o_same, o_gaps, o_stb_ok,
                   e_adr, e_sel, w_r, e_dat, e_att - 1);
        end
      end
      compared++;
      if (o_ready_after !== 1'b1 || o_extra_rsp !== 1'b0) begin
        mismatched++;
        $display("FAIL random_ready[%0d]: ready=%b extra_rsp=%b want 1 0",
                 n, o_ready_after, o_extra_rsp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_retry();
    test_timeout_priority();
    test_reset_mid();
    test_dw64();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
